// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program-counter generator.
package pc_pkg;

  localparam int unsigned      PC_XLEN_DEFAULT         = 64;
  localparam logic [63:0]      PC_RESET_VECTOR_DEFAULT = '0;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } pc_state_e;

  typedef enum logic [1:0] {
    NONE,
    BRANCH,
    TRAP
  } redir_cause_e;

endpackage

// File: rtl/pc_redirect_latch.sv
// Pending-redirect register with trap-over-branch priority merge.
module pc_redirect_latch
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = PC_XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_target,
  input  logic              branch_valid,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              capture,
  input  logic              clear,
  output redir_cause_e      sel_cause,
  output logic [XLEN-1:0]   sel_target,
  output logic              pending,
  output logic [XLEN-1:0]   pend_target
);

  redir_cause_e    cause_q, cause_d, base_cause;
  logic [XLEN-1:0] target_q, target_d;

  // Best redirect among new requests and the held one: new trap, held trap, new branch, held branch.
  always_comb begin
    sel_cause  = cause_q;
    sel_target = target_q;
    if (trap_valid) begin
      sel_cause  = TRAP;
      sel_target = trap_target;
    end else if (cause_q != TRAP && branch_valid) begin
      sel_cause  = BRANCH;
      sel_target = branch_target;
    end
  end

  // Next held redirect: optionally cleared first, then merged with any new request when capturing.
  always_comb begin
    base_cause = clear ? NONE : cause_q;
    cause_d    = base_cause;
    target_d   = target_q;
    if (capture) begin
      if (trap_valid) begin
        cause_d  = TRAP;
        target_d = trap_target;
      end else if (base_cause != TRAP && branch_valid) begin
        cause_d  = BRANCH;
        target_d = branch_target;
      end
    end
  end

  // Pending cause/target registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_q  <= NONE;
      target_q <= '0;
    end else begin
      cause_q  <= cause_d;
      target_q <= target_d;
    end
  end

  assign pending     = (cause_q != NONE);
  assign pend_target = target_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: FSM, PC register, redirect handling, fetch counter.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned      XLEN         = PC_XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(PC_RESET_VECTOR_DEFAULT),
  parameter int unsigned      INST_BYTES   = 4,
  parameter int unsigned      CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_target,
  input  logic              branch_valid,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              pc_ready,
  output logic [XLEN-1:0]   pc_out,
  output logic              pc_valid,
  output logic              redirect_pending,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);
  localparam logic [XLEN-1:0] PC_INC     = XLEN'(INST_BYTES);

  pc_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             capture, clear, apply;
  logic [XLEN-1:0]  apply_target;
  redir_cause_e     sel_cause;
  logic [XLEN-1:0]  sel_target;
  logic             pending;
  logic [XLEN-1:0]  pend_target;

  pc_redirect_latch #(
    .XLEN (XLEN)
  ) u_redirect_latch (
    .clk           (clk),
    .reset_n       (reset_n),
    .trap_valid    (trap_valid),
    .trap_target   (trap_target),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .capture       (capture),
    .clear         (clear),
    .sel_cause     (sel_cause),
    .sel_target    (sel_target),
    .pending       (pending),
    .pend_target   (pend_target)
  );

  // Next state, next PC and latch control for the current cycle.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    capture      = 1'b0;
    clear        = 1'b0;
    apply        = 1'b0;
    apply_target = '0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (stall) begin
          capture = 1'b1;
        end else if (trap_valid) begin
          apply        = 1'b1;
          apply_target = trap_target;
          clear        = 1'b1;
        end else if (halt_req) begin
          // A same-cycle branch is held for resume rather than applied.
          state_d = HALTED;
          capture = 1'b1;
        end else if (sel_cause != NONE) begin
          apply        = 1'b1;
          apply_target = sel_target;
          clear        = 1'b1;
        end else if (pc_ready) begin
          pc_d    = pc_q + PC_INC;
          count_d = count_q + 1'b1;
        end
      end
      HALTED: begin
        if (stall) begin
          capture = 1'b1;
        end else if (trap_valid) begin
          state_d      = RUN;
          apply        = 1'b1;
          apply_target = trap_target;
          clear        = 1'b1;
        end else if (resume) begin
          // Consume the held target; a branch arriving alongside resume becomes the new pending one.
          state_d      = RUN;
          clear        = 1'b1;
          capture      = 1'b1;
          apply        = pending;
          apply_target = pend_target;
        end else begin
          capture = 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    misalign_d = apply && ((apply_target & ALIGN_MASK) != '0);
    if (apply) begin
      pc_d = apply_target & ~ALIGN_MASK;
    end
    pc_valid_d = (state_d == RUN);
  end

  // State, PC, registered outputs and fetch counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign pc_out           = pc_q;
  assign pc_valid         = pc_valid_q;
  assign redirect_pending = pending;
  assign misalign_err     = misalign_q;
  assign fetch_count      = count_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen with default parameters (XLEN=64, RESET_VECTOR=0, INST_BYTES=4).
module tb_pc_gen;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        trap_valid;
  logic [63:0] trap_target;
  logic        branch_valid;
  logic [63:0] branch_target;
  logic        halt_req;
  logic        resume;
  logic        pc_ready;
  logic [63:0] pc_out;
  logic        pc_valid;
  logic        redirect_pending;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef enum int { F_PC, F_VALID, F_PEND, F_MIS, F_CNT } fld_e;
  typedef struct {
    string       tag;
    fld_e        fld;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];

  pc_gen #(
    .XLEN         (64),
    .RESET_VECTOR (64'h0),
    .INST_BYTES   (4),
    .CNT_W        (32)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall            (stall),
    .trap_valid       (trap_valid),
    .trap_target      (trap_target),
    .branch_valid     (branch_valid),
    .branch_target    (branch_target),
    .halt_req         (halt_req),
    .resume           (resume),
    .pc_ready         (pc_ready),
    .pc_out           (pc_out),
    .pc_valid         (pc_valid),
    .redirect_pending (redirect_pending),
    .misalign_err     (misalign_err),
    .fetch_count      (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] observe(input fld_e f);
    case (f)
      F_PC:    return pc_out;
      F_VALID: return 64'(pc_valid);
      F_PEND:  return 64'(redirect_pending);
      F_MIS:   return 64'(misalign_err);
      default: return 64'(fetch_count);
    endcase
  endfunction

  task automatic expect_out(input string tag, input fld_e f, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.fld = f;
    e.val = v;
    sb.push_back(e);
  endtask

  // Expected PC / valid / pending / count after the coming edge.
  task automatic expect_all(input string tag, input logic [63:0] pc, input logic v,
                            input logic p, input logic [31:0] c);
    expect_out({tag, ".pc"},    F_PC,    pc);
    expect_out({tag, ".valid"}, F_VALID, 64'(v));
    expect_out({tag, ".pend"},  F_PEND,  64'(p));
    expect_out({tag, ".cnt"},   F_CNT,   64'(c));
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.fld), e.val);
    end
  endtask

  task automatic drive(input logic st, input logic tv, input logic [63:0] tt, input logic bv,
                       input logic [63:0] bt, input logic hr, input logic rs, input logic rdy);
    stall         = st;
    trap_valid    = tv;
    trap_target   = tt;
    branch_valid  = bv;
    branch_target = bt;
    halt_req      = hr;
    resume        = rs;
    pc_ready      = rdy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive(0, 0, '0, 0, '0, 0, 0, 1);
    #3;
    check("rst.pc",    pc_out, 64'h0);
    check("rst.valid", 64'(pc_valid), 64'h0);
    check("rst.pend",  64'(redirect_pending), 64'h0);
    check("rst.mis",   64'(misalign_err), 64'h0);
    check("rst.cnt",   64'(fetch_count), 64'h0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1 check("boot.valid", 64'(pc_valid), 64'h0);

    // Sequential fetch: 0, 0, 4, 8, 12
    expect_all("seq1", 64'h0, 1, 0, 0); tick();
    expect_all("seq2", 64'h4, 1, 0, 1); tick();
    expect_all("seq3", 64'h8, 1, 0, 2); tick();
    expect_all("seq4", 64'hc, 1, 0, 3); tick();

    // Branch captured during a 3-cycle stall
    drive(1, 0, '0, 0, '0, 0, 0, 1);        expect_all("stl1", 64'hc, 1, 0, 3); tick();
    drive(1, 0, '0, 1, 64'h200, 0, 0, 1);   expect_all("stl2", 64'hc, 1, 1, 3); tick();
    drive(1, 0, '0, 0, '0, 0, 0, 1);        expect_all("stl3", 64'hc, 1, 1, 3); tick();
    drive(0, 0, '0, 0, '0, 0, 0, 1);        expect_all("stl4", 64'h200, 1, 0, 3);
    expect_out("stl4.mis", F_MIS, 64'h0); tick();

    // Trap and branch together: trap wins, branch dropped
    drive(0, 1, 64'h100, 1, 64'h300, 0, 0, 1); expect_all("tb1", 64'h100, 1, 0, 3); tick();
    drive(0, 0, '0, 0, '0, 0, 0, 1);           expect_all("tb2", 64'h104, 1, 0, 4); tick();

    // Stalled branch overridden by later stalled trap; applied with pc_ready low
    drive(1, 0, '0, 1, 64'h300, 0, 0, 1);   expect_all("pri1", 64'h104, 1, 1, 4); tick();
    drive(1, 1, 64'h100, 0, '0, 0, 0, 1);   expect_all("pri2", 64'h104, 1, 1, 4); tick();
    drive(0, 0, '0, 0, '0, 0, 0, 0);        expect_all("pri3", 64'h100, 1, 0, 4); tick();
    drive(0, 0, '0, 0, '0, 0, 0, 1);        expect_all("pri4", 64'h104, 1, 0, 5); tick();

    // Misaligned branch target
    drive(0, 0, '0, 1, 64'h203, 0, 0, 1);   expect_all("mis1", 64'h200, 1, 0, 5);
    expect_out("mis1.mis", F_MIS, 64'h1); tick();
    drive(0, 0, '0, 0, '0, 0, 0, 0);        expect_all("mis2", 64'h200, 1, 0, 5);
    expect_out("mis2.mis", F_MIS, 64'h0); tick();

    // Halt / resume at same PC
    drive(0, 0, '0, 0, '0, 1, 0, 0);        expect_all("hlt1", 64'h200, 0, 0, 5); tick();
    drive(0, 0, '0, 0, '0, 0, 0, 0);        expect_all("hlt2", 64'h200, 0, 0, 5); tick();
    drive(0, 0, '0, 0, '0, 0, 1, 0);        expect_all("hlt3", 64'h200, 1, 0, 5); tick();

    // Halt with same-cycle branch, resume to pending target
    drive(0, 0, '0, 1, 64'h40, 1, 0, 0);    expect_all("hlt4", 64'h200, 0, 1, 5); tick();
    drive(0, 0, '0, 0, '0, 0, 1, 0);        expect_all("hlt5", 64'h40, 1, 0, 5); tick();

    // Trap leaves HALTED
    drive(0, 0, '0, 0, '0, 1, 0, 0);        expect_all("hlt6", 64'h40, 0, 0, 5); tick();
    drive(0, 1, 64'h80, 0, '0, 0, 0, 0);    expect_all("hlt7", 64'h80, 1, 0, 5); tick();

    // Sequential wrap at top of address space
    drive(0, 0, '0, 1, 64'hffff_ffff_ffff_fffc, 0, 0, 0);
    expect_all("wrp1", 64'hffff_ffff_ffff_fffc, 1, 0, 5); tick();
    drive(0, 0, '0, 0, '0, 0, 0, 1);        expect_all("wrp2", 64'h0, 1, 0, 6); tick();
    drive(0, 0, '0, 0, '0, 0, 0, 1);        expect_all("wrp3", 64'h4, 1, 0, 7); tick();

    // Asynchronous reset while halted with a branch pending
    drive(0, 0, '0, 0, '0, 1, 0, 0);        expect_all("ar1", 64'h4, 0, 0, 7); tick();
    drive(0, 0, '0, 1, 64'h500, 0, 0, 0);   expect_all("ar2", 64'h4, 0, 1, 7); tick();
    drive(0, 0, '0, 0, '0, 0, 0, 1);
    #2 reset_n = 1'b0;
    #1;
    check("ar3.pc",    pc_out, 64'h0);
    check("ar3.valid", 64'(pc_valid), 64'h0);
    check("ar3.pend",  64'(redirect_pending), 64'h0);
    check("ar3.cnt",   64'(fetch_count), 64'h0);
    #1 reset_n = 1'b1;
    expect_all("ar4", 64'h0, 1, 0, 0); tick();
    expect_all("ar5", 64'h4, 1, 0, 1); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage. It replaces the single-register PC with several additions:

- a valid/ready handshake to instruction fetch
- prioritised trap and branch redirects
- capture of redirects that arrive while the pipeline is stalled
- a halt state
- an issued-fetch counter

It sits between the branch/exception resolution logic and the instruction memory address port.

## Interface
- `XLEN`, 64: PC width in bits.
- `RESET_VECTOR`, 0: PC value loaded at reset.
- `INST_BYTES`, 4: sequential increment; power of two ≥ 1.
- `CNT_W`, 32: width of the issued-fetch counter.

Ports (the clock is `clk`; reset is `reset_n`, asynchronous assert, active-low):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `stall`  in  1  hold PC; no advance and no redirect applied.
- `trap_valid`  in  1  exception redirect request.
- `trap_target`  in  XLEN  exception handler address.
- `branch_valid`  in  1  branch/jump redirect request.
- `branch_target`  in  XLEN  branch target address.
- `halt_req`  in  1  enter HALTED state.
- `resume`  in  1  leave HALTED state at the current PC.
- `pc_ready`  in  1  fetch accepts the current PC.
- `pc_out`  out  XLEN  current fetch address.
- `pc_valid`  out  1  `pc_out` is a valid fetch request.
- `redirect_pending`  out  1  a redirect is latched and not yet applied.
- `misalign_err`  out  1  one-cycle pulse: an applied target had nonzero low bits.
- `fetch_count`  out  CNT_W  number of completed handshakes (`pc_valid && pc_ready && !stall`).

## Operation
- States: BOOT, RUN, HALTED.
- Reset values:
  - state = BOOT
  - `pc_out` = `RESET_VECTOR`
  - `pc_valid` = 0
  - `redirect_pending` = 0
  - `misalign_err` = 0
  - `fetch_count` = 0
- BOOT → RUN on the first clock edge after reset release, unconditionally. `pc_valid` = 1 in RUN only.
- Next-PC priority in RUN when `!stall`:
  1. new trap
  2. pending trap
  3. new branch
  4. pending branch
  5. sequential (`pc_out + INST_BYTES`, only if `pc_ready`)
  6. hold
- An applied redirect clears pending. A redirect is applied regardless of `pc_ready`, and the current PC is dropped (no count).
- Stall in RUN:
  - `pc_out` holds.
  - Any trap/branch request is latched into the pending register, keeping only the highest-priority request. Trap beats branch; within the same class the newer request wins.
  - `redirect_pending` = 1 from the next cycle.
- Alignment: applied targets have their low log2(`INST_BYTES`) bits forced to 0. `misalign_err` pulses for one cycle after the edge that applied a target whose cleared bits were nonzero.
- `halt_req` in RUN (no stall, no trap this cycle):
  - → HALTED, `pc_out` holds, `pc_valid` = 0.
  - A branch in the same cycle is latched as pending, not applied.
- HALTED:
  - `trap_valid` applies the trap target and → RUN.
  - `resume` → RUN at the held PC, or at the pending target if one exists.
  - Branches are latched only.
- Sequential PC addition wraps modulo 2^XLEN. `fetch_count` wraps modulo 2^CNT_W.

## Timing
- Redirect latency is 1 cycle: a request sampled at edge N produces the target on `pc_out` after edge N.
- Stalled redirect: the pending target appears after the first edge with `stall` = 0.
- Handshake: fetch may sample `pc_out` whenever `pc_valid` = 1. `pc_out` changes only after a handshake or a redirect.
- `reset_n` asserted mid-operation: all outputs take their reset values immediately (asynchronously), and pending is discarded.

## Structure
- Shared package `pc_pkg` holds:
  - state enum `{BOOT, RUN, HALTED}`
  - redirect-cause encoding `{NONE, BRANCH, TRAP}`
  - defaults for `XLEN` and `RESET_VECTOR`
- One natural sub-module: `pc_redirect_latch`, which holds the pending target and cause and does the priority merge.
- The top module holds the FSM, the PC register, and the counter.

## Test plan
- Reset release, `pc_ready` = 1, `INST_BYTES` = 4 → `pc_out` sequence 0, 0, 4, 8, 12. `pc_valid` rises one cycle after release. `fetch_count` = 3 after edge 4.
- Stall high for 3 cycles, `branch_valid` pulse with target 0x200 during cycle 2, then stall drops → `pc_out` holds during the stall, `redirect_pending` = 1, `pc_out` = 0x200 one cycle after release.
- Same cycle: `trap_valid` (target 0x100) and `branch_valid` (target 0x300) → `pc_out` = 0x100, no pending left.
- Stalled branch to 0x300, then trap to 0x100 while still stalled → after release `pc_out` = 0x100.
- `branch_target` = 0x203 → `pc_out` = 0x200, `misalign_err` high for exactly one cycle.
- `halt_req` → `pc_valid` = 0 and PC held. `resume` → `pc_valid` = 1 at the same PC. `reset_n` low mid-halt → `pc_out` = `RESET_VECTOR` immediately. With PC = 2^XLEN − 4 and no redirect, the next PC wraps to 0.
